// File: rtl/fir_axilite_ctrl.sv
// fir_axilite_ctrl: AXI-Lite slave and control-register block for the FIR engine.
// Holds ap_ctrl and data_length, and owns the tap BRAM port. While the engine
// is busy, the engine owns the tap BRAM port and the bus sees protected
// behaviour: tap writes are dropped and tap reads return all ones.
module fir_axilite_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_tap_EN,
  output logic                   ap_start_o,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic                   eng_done
);

  localparam logic [pADDR_WIDTH-1:0] LP_ADDR_CTRL = pADDR_WIDTH'(12'h000);
  localparam logic [pADDR_WIDTH-1:0] LP_ADDR_LEN  = pADDR_WIDTH'(12'h010);
  localparam logic [pADDR_WIDTH-1:0] LP_TAP_BASE  = pADDR_WIDTH'(12'h020);
  localparam logic [pADDR_WIDTH-1:0] LP_TAP_LAST  =
    LP_TAP_BASE + pADDR_WIDTH'(32'd4 * 32'(Tape_Num - 1));

  typedef enum logic [0:0] {W_ADDR = 1'b0, W_DATA = 1'b1} w_state_t;
  typedef enum logic [1:0] {R_ADDR = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;

  // Word-aligned address inside the tap window.
  function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= LP_TAP_BASE) && (a <= LP_TAP_LAST) && (a[1:0] == 2'b00);
  endfunction

  w_state_t               r_w_state, w_w_state_nxt;
  r_state_t               r_r_state, w_r_state_nxt;
  logic                   r_awready, r_wready, r_arready, r_rvalid;
  logic [pADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [pDATA_WIDTH-1:0] r_rdata, r_data_length, w_reg_rdata;
  logic                   r_ap_start, r_ap_done, r_ap_idle;
  logic                   r_rd_issued, r_rd_blocked;
  logic                   w_wr_fire, w_wr_tap, w_wr_len, w_wr_start;
  logic                   w_rd_hs, w_rd_hs_tap, w_rd_issue_now, w_rd_issue_wait;
  logic                   w_rd_ctrl_done;

  // Write-side decode: all commits happen on the wvalid&wready edge.
  assign w_wr_fire  = r_wready & wvalid;
  assign w_wr_tap   = w_wr_fire & f_is_tap(r_awaddr) & r_ap_idle;
  assign w_wr_len   = w_wr_fire & (r_awaddr == LP_ADDR_LEN) & r_ap_idle;
  assign w_wr_start = w_wr_fire & (r_awaddr == LP_ADDR_CTRL) & wdata[0] & r_ap_idle;

  // Read-side decode; a same-cycle tap write takes the BRAM port first.
  assign w_rd_hs         = r_arready & arvalid;
  assign w_rd_hs_tap     = w_rd_hs & f_is_tap(araddr);
  assign w_rd_issue_now  = w_rd_hs_tap & r_ap_idle & ~w_wr_tap;
  assign w_rd_issue_wait = (r_r_state == R_WAIT) & ~r_rd_issued & ~r_rd_blocked &
                           r_ap_idle & ~w_wr_tap;
  assign w_rd_ctrl_done  = (r_r_state == R_DATA) & rready & (r_araddr == LP_ADDR_CTRL);

  assign awready     = r_awready;
  assign wready      = r_wready;
  assign arready     = r_arready;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign ap_start_o  = r_ap_start;
  assign data_length = r_data_length;

  // Write FSM next-state: address phase, then data phase, never overlapping.
  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_ADDR: begin
        if (r_awready && awvalid) begin
          w_w_state_nxt = W_DATA;
        end else begin
          w_w_state_nxt = W_ADDR;
        end
      end
      W_DATA: begin
        if (w_wr_fire) begin
          w_w_state_nxt = W_ADDR;
        end else begin
          w_w_state_nxt = W_DATA;
        end
      end
      default: w_w_state_nxt = W_ADDR;
    endcase
  end

  // Write FSM state, registered ready flags and latched write address.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_w_state <= W_ADDR;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_awready <= (w_w_state_nxt == W_ADDR);
      r_wready  <= (w_w_state_nxt == W_DATA);
      if (r_awready && awvalid) begin
        r_awaddr <= awaddr;
      end
    end
  end

  // Read FSM next-state: taps detour through R_WAIT for the BRAM latency.
  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_ADDR: begin
        if (w_rd_hs) begin
          w_r_state_nxt = w_rd_hs_tap ? R_WAIT : R_DATA;
        end else begin
          w_r_state_nxt = R_ADDR;
        end
      end
      R_WAIT: begin
        if (r_rd_issued || r_rd_blocked || !r_ap_idle) begin
          w_r_state_nxt = R_DATA;
        end else begin
          w_r_state_nxt = R_WAIT;
        end
      end
      R_DATA: begin
        if (rready) begin
          w_r_state_nxt = R_ADDR;
        end else begin
          w_r_state_nxt = R_DATA;
        end
      end
      default: w_r_state_nxt = R_ADDR;
    endcase
  end

  // Read FSM state, registered ready/valid flags and latched read address.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_r_state <= R_ADDR;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_araddr  <= '0;
    end else begin
      r_r_state <= w_r_state_nxt;
      r_arready <= (w_r_state_nxt == R_ADDR);
      r_rvalid  <= (w_r_state_nxt == R_DATA);
      if (w_rd_hs) begin
        r_araddr <= araddr;
      end
    end
  end

  // Tracks whether the tap read reached the BRAM or was refused while busy.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rd_issued  <= 1'b0;
      r_rd_blocked <= 1'b0;
    end else if (w_rd_hs) begin
      r_rd_issued  <= w_rd_issue_now;
      r_rd_blocked <= ~r_ap_idle;
    end else if (w_rd_issue_wait) begin
      r_rd_issued  <= 1'b1;
    end
  end

  // Register read mux for non-tap addresses; unmapped addresses read as zero.
  always_comb begin
    w_reg_rdata = '0;
    if (araddr == LP_ADDR_CTRL) begin
      w_reg_rdata = {{(pDATA_WIDTH-3){1'b0}}, r_ap_idle, r_ap_done, r_ap_start};
    end else if (araddr == LP_ADDR_LEN) begin
      w_reg_rdata = r_data_length;
    end else begin
      w_reg_rdata = '0;
    end
  end

  // Read data register, held stable for the whole R_DATA phase.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_hs && !w_rd_hs_tap) begin
      r_rdata <= w_reg_rdata;
    end else if ((r_r_state == R_WAIT) && r_rd_issued) begin
      r_rdata <= tap_Do;
    end else if ((r_r_state == R_WAIT) && (r_rd_blocked || !r_ap_idle)) begin
      r_rdata <= {pDATA_WIDTH{1'b1}};
    end
  end

  // Sample-count register; frozen while the engine runs.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_data_length <= '0;
    end else if (w_wr_len) begin
      r_data_length <= wdata;
    end
  end

  // ap_ctrl: start pulse, done latch (engine set beats read clear), idle flag.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_ap_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_idle  <= 1'b1;
    end else begin
      r_ap_start <= w_wr_start;
      if (eng_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end else if (w_wr_start) begin
        r_ap_done <= 1'b0;
        r_ap_idle <= 1'b0;
      end else if (w_rd_ctrl_done) begin
        r_ap_done <= 1'b0;
      end
    end
  end

  // Tap BRAM port mux: engine while busy, else AXI write, else AXI read.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (!r_ap_idle) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (w_wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = r_awaddr - LP_TAP_BASE;
      tap_Di = wdata;
    end else if (w_rd_issue_now) begin
      tap_EN = 1'b1;
      tap_A  = araddr - LP_TAP_BASE;
    end else if (w_rd_issue_wait) begin
      tap_EN = 1'b1;
      tap_A  = r_araddr - LP_TAP_BASE;
    end else begin
      tap_EN = 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_axilite_ctrl.sv
// Bench for fir_axilite_ctrl: table of AXI-Lite write/read vectors plus
// hand-written sequences for busy protection, port conflict, back-pressure
// and mid-transaction reset. Includes a behavioural tap BRAM.
module tb_fir_axilite_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = 12'h000, araddr = 12'h000;
  logic [31:0] wdata = 32'h0, rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do;
  logic [11:0] tap_A;
  logic [11:0] eng_tap_A = 12'h000;
  logic        eng_tap_EN = 1'b0;
  logic        ap_start_o;
  logic [31:0] data_length;
  logic        eng_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int start_pulses = 0;

  always #5 clk = ~clk;

  fir_axilite_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_A(eng_tap_A), .eng_tap_EN(eng_tap_EN),
    .ap_start_o(ap_start_o), .data_length(data_length), .eng_done(eng_done)
  );

  // Behavioural tap BRAM: byte-addressed, read-first, 1-cycle read latency.
  logic [31:0] mem [0:15];
  logic [31:0] bram_do = 32'h0;
  assign tap_Do = bram_do;
  always @(posedge clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (tap_WE[b]) mem[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      end
      bram_do <= mem[tap_A[5:2]];
    end
  end

  // Counts cycles with the start pulse high.
  always @(negedge clk) begin
    if (ap_start_o) start_pulses <= start_pulses + 1;
  end

  typedef struct {
    bit          wr;
    bit          is_tap;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] coef [0:10] = '{32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFF7, 32'd23, 32'd56,
                               32'd63, 32'd56, 32'd23, 32'hFFFF_FFF7, 32'hFFFF_FFF6, 32'd0};

  function automatic vec_t mk(bit wr, bit is_tap, logic [11:0] a, logic [31:0] d,
                              logic [31:0] e, int lat);
    vec_t v;
    v.wr = wr; v.is_tap = is_tap; v.addr = a; v.data = d; v.exp = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output logic [16:0] snap);
    int n;
    @(negedge clk); awvalid = 1'b1; awaddr = a;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("awready_timeout", 32'd0, 32'd1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b1; wdata = d;
    n = 0;
    while (wready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("wready_timeout", 32'd0, 32'd1);
    #1 snap = {tap_EN, tap_WE, tap_A};
    @(negedge clk); wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
    int n;
    @(negedge clk); arvalid = 1'b1; araddr = a; rready = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("arready_timeout", 32'd0, 32'd1);
    @(negedge clk); arvalid = 1'b0; lat = 1;
    while (rvalid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) check("rvalid_timeout", 32'd0, 32'd1);
    d = rdata;
    @(negedge clk); rready = 1'b0;
  endtask

  initial begin
    logic [16:0] snap;
    logic [31:0] d;
    int          lat;
    int          p0;
    int          n;

    // Vector table: configure length and taps, then read everything back.
    vecs.push_back(mk(1'b1, 1'b0, 12'h010, 32'd600, 32'd0, 0));
    for (int k = 0; k < 11; k++) vecs.push_back(mk(1'b1, 1'b1, 12'(32'h20 + 4*k), coef[k], 32'd0, 0));
    vecs.push_back(mk(1'b1, 1'b0, 12'h008, 32'd123, 32'd0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 12'h010, 32'd0, 32'd600, 1));
    for (int k = 0; k < 11; k++) vecs.push_back(mk(1'b0, 1'b1, 12'(32'h20 + 4*k), 32'd0, coef[k], 2));
    vecs.push_back(mk(1'b0, 1'b0, 12'h000, 32'd0, 32'h4, 1));
    vecs.push_back(mk(1'b0, 1'b0, 12'h008, 32'd0, 32'd0, 1));
    vecs.push_back(mk(1'b0, 1'b0, 12'h04C, 32'd0, 32'd0, 1));
    vecs.push_back(mk(1'b0, 1'b0, 12'h022, 32'd0, 32'd0, 1));

    // Reset values while reset is held.
    #12;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tap_port", {27'd0, tap_EN, tap_WE}, 32'd0);
    check("rst_start_o", {31'd0, ap_start_o}, 32'd0);
    check("rst_data_length", data_length, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {29'd0, awready, wready, arready}, 32'b101);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, snap);
        if (vecs[i].is_tap)
          check($sformatf("tap_wr_port_%0d", i), {15'd0, snap}, {15'd0, 1'b1, 4'hF, vecs[i].addr - 12'h020});
        else
          check($sformatf("reg_wr_port_%0d", i), {15'd0, snap}, 32'd0);
      end else begin
        axi_read(vecs[i].addr, d, lat);
        check($sformatf("rd_data_%03h", vecs[i].addr), d, vecs[i].exp);
        check($sformatf("rd_lat_%03h", vecs[i].addr), lat, vecs[i].lat);
      end
    end
    check("data_length_out", data_length, 32'd600);

    // Start: exactly one pulse, idle drops; a second start while busy is ignored.
    p0 = start_pulses;
    axi_write(12'h000, 32'h1, snap);
    repeat (4) @(negedge clk);
    check("start_pulse_count", start_pulses - p0, 32'd1);
    axi_read(12'h000, d, lat);
    check("ctrl_busy", d, 32'h0);
    p0 = start_pulses;
    axi_write(12'h000, 32'h1, snap);
    repeat (4) @(negedge clk);
    check("start_ignored_busy", start_pulses - p0, 32'd0);

    // Busy protection: engine owns the port, tap/length writes dropped.
    eng_tap_A = 12'h014; eng_tap_EN = 1'b1;
    axi_write(12'h02C, 32'd99, snap);
    check("busy_tap_port", {15'd0, snap}, {15'd0, 1'b1, 4'h0, 12'h014});
    axi_read(12'h02C, d, lat);
    check("busy_tap_read", d, 32'hFFFF_FFFF);
    check("busy_tap_lat", lat, 32'd2);
    axi_write(12'h010, 32'd5, snap);
    check("busy_len_dropped", data_length, 32'd600);
    eng_tap_EN = 1'b0;
    @(negedge clk); eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    axi_read(12'h000, d, lat);
    check("ctrl_done", d, 32'h6);
    axi_read(12'h000, d, lat);
    check("ctrl_done_cleared", d, 32'h4);
    axi_read(12'h02C, d, lat);
    check("tap3_after_busy", d, 32'd23);

    // Same-cycle tap write and tap read: write wins, read stalls one cycle.
    @(negedge clk); awvalid = 1'b1; awaddr = 12'h034;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("conf_aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'd77;
    arvalid = 1'b1; araddr = 12'h034; rready = 1'b1;
    #1;
    check("conf_ready", {30'd0, wready, arready}, 32'b11);
    check("conf_port", {15'd0, tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'hF, 12'h014});
    @(negedge clk); wvalid = 1'b0; arvalid = 1'b0; lat = 1;
    while (rvalid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    check("conf_lat", lat, 32'd3);
    check("conf_data", rdata, 32'd77);
    @(negedge clk); rready = 1'b0;

    // Back-pressure: rvalid/rdata stable and arready low while rready=0.
    @(negedge clk); arvalid = 1'b1; araddr = 12'h010; rready = 1'b0;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("bp_rvalid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_%0d", i), {rvalid, arready, rdata[29:0]}, {1'b1, 1'b0, 30'd600});
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk); rready = 1'b0;
    check("bp_released", {31'd0, rvalid}, 32'd0);

    // Reset asserted while the write FSM sits in W_DATA.
    @(negedge clk); awvalid = 1'b1; awaddr = 12'h010;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); awvalid = 1'b0;
    check("wdata_phase", {31'd0, wready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {30'd0, awready, wready}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(12'h010, d, lat);
    check("midrst_len", d, 32'd0);
    axi_read(12'h000, d, lat);
    check("midrst_ctrl", d, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_axilite_ctrl.md
Name: fir_axilite_ctrl

Overview:
- AXI-Lite responder and control-register block for the FIR engine; it is the slave end of the configuration bus that the bench and SoC drive.
- Decodes ap_ctrl, data_length and the 11 tap coefficients; owns the tap BRAM port; reports engine status.
- Sits between the AXI-Lite interconnect, the tap BRAM (bram11) and the FIR datapath.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and BRAM address width
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of tap registers

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset, asynchronous, active-low
awvalid/awready  in/out  1/1  write-address handshake
awaddr  in  12  write address
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  32  write data
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  12  read address
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  32  read data
tap_WE  out  4  tap BRAM byte write enable
tap_EN  out  1  tap BRAM enable
tap_Di  out  32  tap BRAM write data
tap_A  out  12  tap BRAM byte address
tap_Do  in  32  tap BRAM read data; valid 1 cycle after EN
eng_tap_A  in  12  engine tap address, used while busy
eng_tap_EN  in  1  engine tap read enable
ap_start_o  out  1  one-cycle start pulse to engine
data_length  out  32  sample count register
eng_done  in  1  one-cycle pulse: last sample output accepted

Behaviour:
- Reset values:
  - awready=0, wready=0, arready=0, rvalid=0, rdata=0.
  - tap_WE=0, tap_EN=0, ap_start_o=0, data_length=0.
  - ap_start=0, ap_done=0, ap_idle=1.
- Register map (all offsets are byte addresses):
  - 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle; bits 31:3 read 0.
  - 0x10 data_length.
  - 0x20+4k, k=0..10: tap k, stored in tap BRAM at address 4k.
  - Other addresses: writes are dropped; reads return 0.
- Write FSM:
  - W_ADDR: awready=1. On awvalid, latch awaddr and go to W_DATA.
  - W_DATA: wready=1. On wvalid, commit the write and return to W_ADDR.
  - awready and wready are never high in the same cycle.
  - Write latency is 1 cycle: the register or BRAM is updated at the wvalid&wready edge. A tap write drives tap_EN=1, tap_WE=4'hF, tap_A=4k in that cycle.
- Read FSM:
  - R_ADDR: arready=1. On arvalid, latch araddr; go to R_WAIT for a tap access, otherwise to R_DATA.
  - R_WAIT: one cycle waiting for BRAM output.
  - R_DATA: rvalid=1 with rdata held stable until rready; then return to R_ADDR.
  - Latency from arvalid&arready to rvalid: 1 cycle for registers, 2 cycles for taps.
- Simultaneous tap write and tap read in the same cycle: the write wins the BRAM port and the read stalls in R_WAIT one extra cycle.
- ap_ctrl behaviour:
  - Writing 0x00 with bit0=1 while ap_idle=1 sets ap_start, clears ap_idle and ap_done, and pulses ap_start_o for exactly 1 cycle. ap_start self-clears the next cycle.
  - A start write while ap_idle=0 is ignored.
  - eng_done sets ap_done=1 and ap_idle=1.
  - A read of 0x00 that completes (rvalid&rready) clears ap_done the cycle after, unless eng_done fires in that same cycle (set wins).
- Busy protection (ap_idle=0):
  - The tap BRAM port is muxed to eng_tap_A/eng_tap_EN with tap_WE=0.
  - AXI tap writes are dropped; AXI tap reads return 32'hFFFFFFFF; data_length writes are dropped.
  - The handshakes still complete so the bus never hangs.
- Reset asserted mid-transaction: all FSMs return to their address states and all registers take reset values. A pending rvalid is deasserted.

Test Plan:
1. Write 0x10=600, then taps {0,-10,-9,23,56,63,56,23,-9,-10,0} -> readback of 0x10 = 600 and each tap matches exactly; tap write cycles show tap_WE=4'hF, tap_A=4k.
2. Read 0x00 after reset -> rdata=0x4; write 0x00=1 -> ap_start_o high exactly 1 cycle; next read of 0x00 gives bit2=0.
3. While busy: write tap 3=99, read tap 3 -> rdata=0xFFFFFFFF and eng_tap_A drives tap_A; after eng_done, reading tap 3 returns 23.
4. Pulse eng_done -> read 0x00 returns 0x6; a second read returns 0x4.
5. Hold rready=0 for 5 cycles during a read of 0x10 -> rvalid and rdata stay stable, arready=0 throughout.
6. Assert axis_rst_n=0 while in W_DATA -> awready=0, wready=0 immediately; after release, 0x10 reads 0 and ap_ctrl reads 0x4.
